alpha_sweep_ctrl: RTL

ALPHA_SWEEP_CTRL -- requirements
Module: alpha_sweep_ctrl

---
 rtl/alpha_sweep_if.sv | 36 +++
 rtl/alpha_sweep_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/alpha_sweep_if.sv
// Sweep control, host read port and alpha RAM port of the alpha sweep controller.
// The master side drives the requests and the RAM read data; the slave side is the controller.
interface alpha_sweep_if #(
   parameter int num_qubit = 3
);
   logic                 start;
   logic [7:0]           delta;
   logic [num_qubit-1:0] cond_mask;
   logic [num_qubit-1:0] cond_val;
   logic                 busy;
   logic                 done;

   logic                 host_req;
   logic [num_qubit-1:0] host_addr;
   logic                 host_gnt;
   logic [7:0]           host_rdata;
   logic                 host_rvalid;

   logic [num_qubit-1:0] ram_read_address;
   logic [num_qubit-1:0] ram_write_address;
   logic                 ram_write_enable;
   logic [7:0]           ram_write_alpha;
   logic [7:0]           ram_read_alpha;

   modport master (
      output start, delta, cond_mask, cond_val, host_req, host_addr, ram_read_alpha,
      input  busy, done, host_gnt, host_rdata, host_rvalid,
             ram_read_address, ram_write_address, ram_write_enable, ram_write_alpha
   );

   modport slave (
      input  start, delta, cond_mask, cond_val, host_req, host_addr, ram_read_alpha,
      output busy, done, host_gnt, host_rdata, host_rvalid,
             ram_read_address, ram_write_address, ram_write_enable, ram_write_alpha
   );
endinterface

// File: rtl/alpha_sweep_ctrl.sv
// Walks every alpha RAM address once, adding delta to entries whose address matches
// (cond_mask, cond_val); host reads are served only while the controller is idle.
module alpha_sweep_ctrl #(
   parameter int num_qubit = 3
) (
   input  logic         clk,
   input  logic         rst,
   alpha_sweep_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

   state_t               r_state;
   logic [num_qubit-1:0] r_cnt;
   logic [num_qubit-1:0] r_mask;
   logic [num_qubit-1:0] r_val;
   logic [num_qubit-1:0] r_wr_addr;
   logic [7:0]           r_delta;
   logic                 r_wr_pend;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_rvalid;

   logic                 w_gnt;
   logic                 w_match;
   logic                 w_last;

   // start has priority over a host read issued in the same idle cycle
   assign w_gnt   = !rst && (r_state == S_IDLE) && bus.host_req && !bus.start;
   assign w_match = ((r_cnt & r_mask) == r_val);
   assign w_last  = (r_cnt == {num_qubit{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_mask    <= '0;
         r_val     <= '0;
         r_wr_addr <= '0;
         r_delta   <= '0;
         r_wr_pend <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_rvalid <= w_gnt;
         case (r_state)
            S_IDLE: begin
               r_wr_pend <= 1'b0;
               if (bus.start) begin
                  r_delta <= bus.delta;
                  r_mask  <= bus.cond_mask;
                  r_val   <= bus.cond_val;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               // the write for this address lands next cycle, once its read data returns
               r_wr_pend <= w_match;
               r_wr_addr <= r_cnt;
               r_cnt     <= r_cnt + 1'b1;
               if (w_last) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_wr_pend <= 1'b0;
               r_done    <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy              = r_busy;
   assign bus.done              = r_done;
   assign bus.host_gnt          = w_gnt;
   assign bus.host_rvalid       = r_rvalid;
   assign bus.host_rdata        = r_rvalid ? bus.ram_read_alpha : 8'h00;
   assign bus.ram_read_address  = (r_state == S_SWEEP) ? r_cnt :
                                  w_gnt                 ? bus.host_addr : '0;
   assign bus.ram_write_enable  = r_wr_pend;
   assign bus.ram_write_address = r_wr_addr;
   assign bus.ram_write_alpha   = r_wr_pend ? (bus.ram_read_alpha + r_delta) : 8'h00;

endmodule
